// File: rtl/mat_mem_uart_tx.sv
// Row-major ROWS x COLS matrix reader: each element goes out MSB byte first as 8N1 UART frames, optionally followed by ','/'\n'.
// Latency: first start bit 3 clocks after the start edge. No backpressure: the memory must return data one clock after mem_rd_en.
module mat_mem_uart_tx #(
    parameter int          ROWS         = 3,
    parameter int          COLS         = 3,
    parameter int          DATA_W       = 16,
    parameter int          ADDR_W       = 8,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int          CNT_W        = 4,
    parameter int          CLKS_PER_BIT = 10417,
    parameter int          SEP_EN       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_R_mat,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tx_data,
    output logic              tx_status,
    output logic [4:0]        state_LED,
    output logic [CNT_W-1:0]  values_sent_count,
    output logic              done
);

    localparam int NBYTES  = DATA_W / 8;
    localparam int NFRAMES = NBYTES + ((SEP_EN != 0) ? 1 : 0);
    localparam int CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CLK_W-1:0]  LAST_CLK   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_COL   = 4'(COLS - 1);
    localparam logic [3:0]        LAST_ROW   = 4'(ROWS - 1);
    localparam logic [2:0]        LAST_FRAME = 3'(NFRAMES - 1);
    localparam logic [3:0]        STOP_BIT   = 4'd9;
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FETCH = 5'b00010,
        S_LOAD  = 5'b00100,
        S_SEND  = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t             state_q, state_d;
    logic               read_r_prev_q;
    logic [3:0]         r_q, r_d;
    logic [3:0]         c_q, c_d;
    logic [CLK_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [3:0]         bit_idx_q, bit_idx_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0]  value_q, value_d;
    logic               tx_q, tx_d;
    logic               status_q, status_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               start;
    logic               bit_end;
    logic               frame_end;
    logic               value_end;
    logic [7:0]         cur_byte;
    logic               frame_bit;

    assign start     = read_R_mat & ~read_r_prev_q;
    assign bit_end   = (clk_cnt_q == LAST_CLK);
    assign frame_end = bit_end && (bit_idx_q == STOP_BIT);
    assign value_end = frame_end && (byte_idx_q == LAST_FRAME);

    // Frames past the data bytes carry the separator for the current column.
    always_comb begin
        cur_byte = (c_q == LAST_COL) ? 8'h0A : 8'h2C;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_idx_q == 3'(NBYTES - 1 - i)) begin
                cur_byte = value_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (bit_idx_q)
            4'd0:     frame_bit = 1'b0;
            STOP_BIT: frame_bit = 1'b1;
            default:  frame_bit = cur_byte[3'(bit_idx_q - 4'd1)];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        value_d    = value_q;
        tx_d       = 1'b1;
        status_d   = status_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    cnt_d    = '0;
                    status_d = 1'b1;
                    r_d      = '0;
                    c_d      = '0;
                    addr_d   = BASE;
                    rd_en_d  = 1'b1;
                end
            end
            S_FETCH: begin
                state_d    = S_LOAD;
                clk_cnt_d  = '0;
                bit_idx_d  = '0;
                byte_idx_d = '0;
            end
            S_LOAD: begin
                state_d = S_SEND;
                value_d = mem_rdata;
            end
            S_SEND: begin
                // tx lags the counters by one clock, so the final stop-bit cycle overlaps FETCH.
                tx_d = frame_bit;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == STOP_BIT) begin
                        bit_idx_d  = '0;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
                if (value_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (c_q == LAST_COL) begin
                        c_d = '0;
                        r_d = r_q + 4'd1;
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                    if ((c_q == LAST_COL) && (r_q == LAST_ROW)) begin
                        state_d  = S_DONE;
                        status_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        rd_en_d = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!read_R_mat) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                status_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            read_r_prev_q <= 1'b0;
            r_q           <= '0;
            c_q           <= '0;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            byte_idx_q    <= '0;
            value_q       <= '0;
            tx_q          <= 1'b1;
            status_q      <= 1'b0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            addr_q        <= BASE;
        end else begin
            state_q       <= state_d;
            read_r_prev_q <= read_R_mat;
            r_q           <= r_d;
            c_q           <= c_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            byte_idx_q    <= byte_idx_d;
            value_q       <= value_d;
            tx_q          <= tx_d;
            status_q      <= status_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
        end
    end

    assign mem_addr          = addr_q;
    assign mem_rd_en         = rd_en_q;
    assign tx_data           = tx_q;
    assign tx_status         = status_q;
    assign state_LED         = state_q;
    assign values_sent_count = cnt_q;
    assign done              = done_q;

endmodule

// File: tb/tb_mat_mem_uart_tx.sv
// Directed bench for mat_mem_uart_tx: three instances (16-bit with/without separators, 8-bit 3x3 at base 0x10).
module tb_mat_mem_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] rd;
    int         cyc = 0;
    int         nchk = 0;
    int         nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    wire [7:0]  addr_a, addr_b, addr_c;
    wire        en_a, en_b, en_c;
    logic [15:0] rdata_a, rdata_b;
    logic [7:0] rdata_c;
    wire        tx_a, tx_b, tx_c, st_a, st_b, st_c, done_a, done_b, done_c;
    wire [4:0]  led_a, led_b, led_c;
    wire [3:0]  vsc_a, vsc_b, vsc_c;
    wire [2:0]  txl = {tx_c, tx_b, tx_a};

    logic [15:0] mem_ab [4] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};

    always @(posedge clk) begin
        if (en_a) rdata_a <= mem_ab[addr_a[1:0]];
        if (en_b) rdata_b <= mem_ab[addr_b[1:0]];
        if (en_c) rdata_c <= addr_c - 8'h0F;
    end

    mat_mem_uart_tx #(.ROWS(2), .COLS(2), .DATA_W(16), .ADDR_W(8), .BASE_ADDR(0), .CNT_W(4),
                      .CLKS_PER_BIT(CPB), .SEP_EN(1)) u_a (
        .clk(clk), .rst(rst_n), .read_R_mat(rd[0]), .mem_addr(addr_a), .mem_rd_en(en_a),
        .mem_rdata(rdata_a), .tx_data(tx_a), .tx_status(st_a), .state_LED(led_a),
        .values_sent_count(vsc_a), .done(done_a));

    mat_mem_uart_tx #(.ROWS(2), .COLS(2), .DATA_W(16), .ADDR_W(8), .BASE_ADDR(0), .CNT_W(4),
                      .CLKS_PER_BIT(CPB), .SEP_EN(0)) u_b (
        .clk(clk), .rst(rst_n), .read_R_mat(rd[1]), .mem_addr(addr_b), .mem_rd_en(en_b),
        .mem_rdata(rdata_b), .tx_data(tx_b), .tx_status(st_b), .state_LED(led_b),
        .values_sent_count(vsc_b), .done(done_b));

    mat_mem_uart_tx #(.ROWS(3), .COLS(3), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(8'h10), .CNT_W(4),
                      .CLKS_PER_BIT(CPB), .SEP_EN(1)) u_c (
        .clk(clk), .rst(rst_n), .read_R_mat(rd[2]), .mem_addr(addr_c), .mem_rd_en(en_c),
        .mem_rdata(rdata_c), .tx_data(tx_c), .tx_status(st_c), .state_LED(led_c),
        .values_sent_count(vsc_c), .done(done_c));

    int         dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
    logic [4:0] dled_a, dled_c;
    logic [3:0] dvsc_a, dvsc_c;
    logic [7:0] addr_log [$];
    logic       prev_en_c = 1'b0;
    int         dbl_en_c = 0;

    always @(negedge clk) begin
        if (done_a) begin dcnt_a++; dled_a = led_a; dvsc_a = vsc_a; end
        if (done_b) dcnt_b++;
        if (done_c) begin dcnt_c++; dled_c = led_c; dvsc_c = vsc_c; end
        if (en_c) addr_log.push_back(addr_c);
        if (en_c && prev_en_c) dbl_en_c++;
        prev_en_c = en_c;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receives one frame starting at the first low on the selected line; checks every bit lasts CPB clocks.
    task automatic rx_byte(input int sel, output logic [7:0] b, output int t0);
        logic [9:0] fr;
        int         w = 0;
        int         glitch = 0;
        b  = 8'h00;
        t0 = cyc;
        while (txl[sel] !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (txl[sel] !== 1'b0) begin
            check("rx_start_timeout", 32'(txl[sel]), 32'd0);
            return;
        end
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            fr[i] = txl[sel];
            for (int k = 0; k < CPB; k++) begin
                if (txl[sel] !== fr[i]) glitch++;
                @(negedge clk);
            end
        end
        check("bit_width", 32'(glitch), 32'd0);
        check("stop_bit", 32'(fr[9]), 32'd1);
        b = fr[8:1];
    endtask

    logic [7:0] exp_q [$];

    task automatic rx_stream(input int sel, input int fpv, input int e0);
        logic [7:0] b;
        int         t;
        for (int i = 0; i < exp_q.size(); i++) begin
            rx_byte(sel, b, t);
            check($sformatf("byte%0d", i), 32'(b), 32'(exp_q[i]));
            check($sformatf("t_byte%0d", i), 32'(t - e0), 32'(3 + i*40 + (i/fpv)*2));
        end
    endtask

    task automatic pulse(input int sel, output int e0);
        @(negedge clk);
        rd[sel] = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        rd[sel] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, d0, lows;
        rst_n = 1'b0;
        rd    = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_a), 32'd1);
        check("rst_status", 32'(st_a), 32'd0);
        check("rst_led", 32'(led_a), 32'h01);
        check("rst_vsc", 32'(vsc_a), 32'd0);
        check("rst_rd_en", 32'(en_a), 32'd0);
        check("rst_addr_a", 32'(addr_a), 32'h00);
        check("rst_addr_c", 32'(addr_c), 32'h10);
        check("rst_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: separators on, single pulse
        exp_q = '{8'h12, 8'h34, 8'h2C, 8'hAB, 8'hCD, 8'h0A, 8'h00, 8'h01, 8'h2C, 8'hFF, 8'h00, 8'h0A};
        pulse(0, e0);
        check("t1_status", 32'(st_a), 32'd1);
        check("t1_led_fetch", 32'(led_a), 32'h02);
        rx_stream(0, 3, e0);
        repeat (5) @(negedge clk);
        check("t1_done_cnt", 32'(dcnt_a), 32'd1);
        check("t1_led_at_done", 32'(dled_a), 32'h10);
        check("t1_vsc_at_done", 32'(dvsc_a), 32'd4);
        check("t1_vsc_end", 32'(vsc_a), 32'd4);
        check("t1_led_idle", 32'(led_a), 32'h01);

        // Test 6: second transfer restarts the count and repeats the stream
        pulse(0, e0);
        check("t6_vsc_clear", 32'(vsc_a), 32'd0);
        rx_stream(0, 3, e0);
        repeat (5) @(negedge clk);
        check("t6_done_cnt", 32'(dcnt_a), 32'd2);
        check("t6_vsc_end", 32'(vsc_a), 32'd4);

        // Test 2: no separators
        exp_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};
        pulse(1, e0);
        rx_stream(1, 2, e0);
        repeat (5) @(negedge clk);
        check("t2_done_cnt", 32'(dcnt_b), 32'd1);
        check("t2_vsc_end", 32'(vsc_b), 32'd4);

        // Test 3: level held high, re-raised while busy
        d0 = dcnt_b;
        @(negedge clk);
        rd[1] = 1'b1;
        e0 = cyc + 1;
        fork
            rx_stream(1, 2, e0);
            begin
                repeat (20) @(negedge clk);
                rd[1] = 1'b0;
                repeat (5) @(negedge clk);
                rd[1] = 1'b1;
            end
        join
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_b !== 1'b1) lows++;
        end
        check("t3_no_retrigger", 32'(lows), 32'd0);
        check("t3_one_done", 32'(dcnt_b - d0), 32'd1);
        check("t3_led_held", 32'(led_b), 32'h10);
        check("t3_status_low", 32'(st_b), 32'd0);
        rd[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_led_idle", 32'(led_b), 32'h01);
        pulse(1, e0);
        rx_stream(1, 2, e0);
        repeat (5) @(negedge clk);
        check("t3_second_done", 32'(dcnt_b - d0), 32'd2);

        // Test 5: 8-bit 3x3 at base 0x10
        exp_q = {};
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(8'(i));
            exp_q.push_back((i % 3 == 0) ? 8'h0A : 8'h2C);
        end
        addr_log = {};
        pulse(2, e0);
        rx_stream(2, 2, e0);
        repeat (5) @(negedge clk);
        check("t5_addr_count", 32'(addr_log.size()), 32'd9);
        for (int i = 0; i < addr_log.size() && i < 9; i++)
            check($sformatf("t5_addr%0d", i), 32'(addr_log[i]), 32'(8'h10 + i));
        check("t5_rd_en_single", 32'(dbl_en_c), 32'd0);
        check("t5_done_cnt", 32'(dcnt_c), 32'd1);
        check("t5_led_at_done", 32'(dled_c), 32'h10);
        check("t5_vsc_at_done", 32'(dvsc_c), 32'd9);
        check("t5_status", 32'(st_c), 32'd0);

        // Test 4: asynchronous reset during the second byte
        d0 = dcnt_a;
        exp_q = '{8'h12};
        pulse(0, e0);
        rx_stream(0, 3, e0);
        repeat (15) @(negedge clk);
        check("t4_mid_frame_busy", 32'(st_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_rst_tx", 32'(tx_a), 32'd1);
        check("t4_rst_led", 32'(led_a), 32'h01);
        check("t4_rst_vsc", 32'(vsc_a), 32'd0);
        check("t4_rst_status", 32'(st_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
        end
        check("t4_idle_after_rst", 32'(lows), 32'd0);
        check("t4_no_done", 32'(dcnt_a - d0), 32'd0);
        check("t4_led_idle", 32'(led_a), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/mat_mem_uart_tx.md
Name: mat_mem_uart_tx

Overview:
- Parametrised result-matrix transmitter; successor to the fixed 3-value memory-to-UART sender.
- On a start request it reads a ROWS x COLS matrix of DATA_W-bit values, row-major, from a synchronous-read result memory.
- Serialises each value as DATA_W/8 bytes over an 8N1 UART line, with optional ASCII separators, and exposes progress and state to the board LEDs.

Parameters:
- ROWS, 3, matrix rows (1..15)
- COLS, 3, matrix columns (1..15)
- DATA_W, 16, element width; multiple of 8, range 8..32
- ADDR_W, 8, memory address width
- BASE_ADDR, 0, address of element (0,0)
- CNT_W, 4, width of values_sent_count; 2^CNT_W > ROWS*COLS required
- CLKS_PER_BIT, 10417, clocks per UART bit (100 MHz / 9600 baud)
- SEP_EN, 1, 1 = append 8'h2C after each non-last column and 8'h0A after each row's last column

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- read_R_mat  in  1  start request; level input, rising edge starts a transfer
- mem_addr  out  ADDR_W  read address, registered
- mem_rd_en  out  1  read strobe, registered
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_rd_en
- tx_data  out  1  UART serial line, idle high
- tx_status  out  1  high while a transfer is in progress
- state_LED  out  5  one-hot FSM state
- values_sent_count  out  CNT_W  values fully transmitted in the current or last transfer
- done  out  1  one-cycle pulse at transfer completion

Behaviour:
- Reset (rst=0, asynchronous): tx_data=1, tx_status=0, state_LED=5'b00001, values_sent_count=0, mem_rd_en=0, mem_addr=BASE_ADDR, done=0. The edge-detect register clears to 0.
- Reset mid-frame aborts the transfer: the line returns high immediately and nothing resumes after release.
- All outputs are registered.
- Start detection: read_r_prev is registered every cycle. Start = read_R_mat & ~read_r_prev, sampled in IDLE only. Starts seen in any other state are ignored.
- FSM states, encoded on state_LED:
  - IDLE = 00001
  - FETCH = 00010
  - LOAD = 00100
  - SEND = 01000
  - DONE = 10000
- IDLE -> FETCH on start. values_sent_count clears to 0 and tx_status goes to 1 on the same edge.
- FETCH, 1 cycle: mem_rd_en=1, mem_addr = BASE_ADDR + r*COLS + c. Next state is LOAD.
- LOAD, 1 cycle: mem_rd_en=0. On the exit edge mem_rdata is captured into the value register. Next state is SEND.
- SEND transmits the value as DATA_W/8 bytes, most-significant byte first. If SEP_EN=1 it then sends one separator byte: 8'h2C if c<COLS-1, else 8'h0A.
- Each byte is an 8N1 frame: start bit 0, data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles. Bytes within one value are back-to-back with no idle gap.
- After the last stop bit of a value: values_sent_count increments, then c increments.
  - When c wraps from COLS-1 to 0, r increments.
  - If the element was (ROWS-1, COLS-1), next state is DONE; otherwise FETCH.
- Line idle-high gap between values is 2 cycles (FETCH + LOAD).
- Latency: if the start edge is sampled on clock edge E0, tx_data first drives 0 on edge E0+3.
- On entry to DONE: tx_status=0, done=1 for exactly one cycle, and values_sent_count holds ROWS*COLS.
- DONE -> IDLE once read_R_mat=0. Holding read_R_mat high never retriggers a transfer.
- Total cycles in SEND per transfer = ROWS*COLS * (DATA_W/8 + SEP_EN) * 10 * CLKS_PER_BIT.

Test Plan:
1. ROWS=2, COLS=2, DATA_W=16, CLKS_PER_BIT=4, SEP_EN=1, memory {0x1234, 0xABCD, 0x0001, 0xFF00}; pulse read_R_mat.
   - Decoded bytes: 12 34 2C AB CD 0A 00 01 2C FF 00 0A.
   - values_sent_count ends at 4, done pulses exactly once, state_LED ends 10000.
2. Same memory, SEP_EN=0.
   - Decoded bytes: 12 34 AB CD 00 01 FF 00.
   - Each bit is exactly 4 cycles; first start bit is 3 cycles after the start edge; gap between values is 2 cycles.
3. Hold read_R_mat high through and after completion, then raise it again while busy.
   - Exactly one transfer occurs; a new transfer starts only after a 1->0->1 sequence seen from IDLE.
4. Assert rst=0 mid-frame, during the 2nd byte.
   - Same cycle: tx_data=1, state_LED=00001, values_sent_count=0, tx_status=0.
   - After release the line stays high until a new rising edge on read_R_mat.
5. DATA_W=8, ROWS=3, COLS=3, BASE_ADDR=8'h10, memory 0x10..0x18 = 1..9.
   - mem_addr sequence is 10..18 with mem_rd_en one cycle each.
   - 9 data bytes, each followed by 2C or 0A; values_sent_count = 9.
6. Second transfer after DONE->IDLE.
   - values_sent_count restarts at 0 and the output byte stream is identical to the first transfer.
